product_display: RTL

- Downstream consumer of the 4x4 sequential multiplier's 8-bit product.
- Converts the product to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes those digits onto a 4-digit common-anode seven-segment display.
- Sits between the multiplier and the board's display pins.

---
 rtl/product_display.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/product_display.sv
// Converts an 8-bit product to three BCD digits with a double-dabble FSM and
// scans them onto a 4-digit common-anode seven-segment display.
module product_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] product,
  output logic [3:0] bcd_hundreds,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       conv_done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {CONV_IDLE, ADJUST, SHIFT, LATCH} state_t;

  state_t          r_state;
  logic [19:0]     r_shift;
  logic [2:0]      r_count;
  logic [7:0]      r_last_value;
  logic [CW-1:0]   r_refresh_cnt;
  logic [1:0]      r_digit_sel;

  logic [19:0]     w_adjusted;
  logic [3:0]      w_digit;
  logic            w_blank;
  logic [3:0]      w_an;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_adjusted = {add3(r_shift[19:16]), add3(r_shift[15:12]),
                       add3(r_shift[11:8]), r_shift[7:0]};

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= CONV_IDLE;
      r_shift      <= '0;
      r_count      <= '0;
      r_last_value <= '0;
      bcd_hundreds <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      conv_done    <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (r_state)
        CONV_IDLE: begin
          if (product != r_last_value) begin
            r_shift      <= {12'd0, product};
            r_count      <= '0;
            r_last_value <= product;
            r_state      <= ADJUST;
          end
        end
        ADJUST: begin
          r_shift <= w_adjusted;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_shift <= {r_shift[18:0], 1'b0};
          r_count <= r_count + 3'd1;
          r_state <= (r_count == 3'd7) ? LATCH : ADJUST;
        end
        LATCH: begin
          bcd_hundreds <= r_shift[19:16];
          bcd_tens     <= r_shift[15:12];
          bcd_ones     <= r_shift[11:8];
          conv_done    <= 1'b1;
          r_state      <= CONV_IDLE;
        end
        default: r_state <= CONV_IDLE;
      endcase
    end
  end

  // Slot select: 0 = ones, 1 = tens, 2 = hundreds; leading zeros blank.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_digit = bcd_ones;
    w_blank = 1'b0;
    w_an    = 4'b1111;
    case (r_digit_sel)
      2'd0: begin
        w_digit = bcd_ones;
        w_an    = 4'b1110;
      end
      2'd1: begin
        w_digit = bcd_tens;
        w_blank = (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0);
        w_an    = 4'b1101;
      end
      2'd2: begin
        w_digit = bcd_hundreds;
        w_blank = (bcd_hundreds == 4'd0);
        w_an    = 4'b1011;
      end
      default: begin
        w_digit = 4'hF;
        w_blank = 1'b1;
        w_an    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 2'd0;
      an            <= 4'b1111;
      seg           <= 7'b1111111;
    end else begin
      if (r_refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        r_refresh_cnt <= '0;
        r_digit_sel   <= (r_digit_sel == 2'd2) ? 2'd0 : r_digit_sel + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end
      an  <= w_an;
      seg <= w_blank ? 7'b1111111 : seg_of(w_digit);
    end
  end

endmodule
